// File: rtl/fir_mac_sequencer.sv
// Sequencer for a single-MAC FIR: writes each accepted sample into a circular
// delay line, walks TAPS coefficient/sample address pairs, and strobes the accumulator.
module fir_mac_sequencer #(
  parameter int TAPS   = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  output logic              cfg_ack,
  output logic              coef_we,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              dl_we,
  output logic [ADDR_W-1:0] dl_waddr,
  output logic [ADDR_W-1:0] dl_raddr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_valid,
  output logic              busy
);

  // Handshake: a sample transfers in any cycle where sample_valid && sample_ready;
  // a cfg write transfers in the cycle cfg_ack is high, the requester holds cfg_we until then.
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W:0]   TAPS_W = (ADDR_W + 1)'(TAPS);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              acc_en_q, acc_en_d;
  logic              acc_clr_q, acc_clr_d;
  logic              accept;
  logic [ADDR_W:0]   diff;

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    base_d       = base_q;
    idx_d        = idx_q;
    sample_ready = (state_q == IDLE) || (state_q == DONE);
    accept       = sample_ready && sample_valid;
    cfg_ack      = cfg_we && (state_q == IDLE) && !sample_valid;
    coef_we      = cfg_ack;
    dl_we        = accept;
    dl_waddr     = wptr_q;
    busy         = (state_q == RUN) || (state_q == DRAIN);
    out_valid    = (state_q == DONE);
    // RAM reads take one cycle, so the accumulator strobes trail RUN by one cycle.
    acc_en_d     = (state_q == RUN);
    acc_clr_d    = (state_q == RUN) && (idx_q == '0);
    coef_addr    = '0;
    dl_raddr     = '0;

    // Explicit modulo so TAPS need not be a power of two.
    if (base_q >= idx_q) diff = {1'b0, base_q} - {1'b0, idx_q};
    else                 diff = {1'b0, base_q} + TAPS_W - {1'b0, idx_q};

    case (state_q)
      IDLE, DONE: begin
        if (cfg_ack) coef_addr = cfg_addr;
        if (accept) begin
          base_d  = wptr_q;
          wptr_d  = (wptr_q == LAST) ? '0 : wptr_q + ADDR_W'(1);
          idx_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        coef_addr = idx_q;
        dl_raddr  = diff[ADDR_W-1:0];
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      base_q    <= '0;
      idx_q     <= '0;
      acc_en_q  <= 1'b0;
      acc_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      acc_en_q  <= acc_en_d;
      acc_clr_q <= acc_clr_d;
    end
  end

  assign acc_en  = acc_en_q;
  assign acc_clr = acc_clr_q;

endmodule
